// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcode constants, immediate formats, widths.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_R,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; result sign-extended to XLEN.
module imm_gen #(
  parameter int XLEN = 32
) (
  input  logic [31:7]         i_instr,
  input  riscv_pkg::imm_fmt_t i_fmt,
  output logic [XLEN-1:0]     o_imm
);
  import riscv_pkg::*;

  logic [31:0] w_imm32;

  always_comb begin
    w_imm32 = '0;
    case (i_fmt)
      IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                          i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U:   w_imm32 = {i_instr[31:12], 12'b0};
      IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                          i_instr[20], i_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: ID register, busy-bit RAW scoreboard, ID/EX pipeline register.
// Optional WB_BYPASS_EN: issue in the writeback cycle using wb_data for the cleared source.
module id_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  input  logic [XLEN-1:0] read_data1,
  input  logic [XLEN-1:0] read_data2,
  input  logic            wb_wEn,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic            ex_rd_wen,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_illegal
);
  import riscv_pkg::*;

  logic            r_id_valid;
  logic [31:0]     r_id_instr;
  logic [XLEN-1:0] r_id_pc;
  logic [31:0]     r_busy;
  logic [31:0]     w_busy_nxt;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic            w_use1, w_use2, w_wen_fmt, w_rd_wen, w_illegal;
  imm_fmt_t        w_fmt;
  logic [XLEN-1:0] w_imm, w_op1, w_op2;
  logic            w_wb_clr, w_src1_busy, w_src2_busy, w_hazard, w_issue;

  assign w_opcode = r_id_instr[6:0];
  assign w_rd     = r_id_instr[11:7];
  assign rs1      = r_id_instr[19:15];
  assign rs2      = r_id_instr[24:20];

  always_comb begin
    w_use1    = 1'b0;
    w_use2    = 1'b0;
    w_wen_fmt = 1'b0;
    w_illegal = 1'b0;
    w_fmt     = IMM_R;
    case (w_opcode)
      OP_R:             begin w_use1 = 1'b1; w_use2 = 1'b1; w_wen_fmt = 1'b1; end
      OP_IMM, OP_LOAD:  begin w_use1 = 1'b1; w_wen_fmt = 1'b1; w_fmt = IMM_I; end
      OP_STORE:         begin w_use1 = 1'b1; w_use2 = 1'b1; w_fmt = IMM_S; end
      OP_BRANCH:        begin w_use1 = 1'b1; w_use2 = 1'b1; w_fmt = IMM_B; end
      OP_JAL:           begin w_wen_fmt = 1'b1; w_fmt = IMM_J; end
      OP_JALR:          begin w_use1 = 1'b1; w_wen_fmt = 1'b1; w_fmt = IMM_I; end
      OP_LUI, OP_AUIPC: begin w_wen_fmt = 1'b1; w_fmt = IMM_U; end
      default:          w_illegal = 1'b1;
    endcase
  end

  assign w_rd_wen = w_wen_fmt && (w_rd != '0);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr (r_id_instr[31:7]),
    .i_fmt   (w_fmt),
    .o_imm   (w_imm)
  );

  assign w_wb_clr = wb_wEn && (wb_rd != '0);

`ifdef WB_BYPASS_EN
  logic w_hit1, w_hit2;
  assign w_hit1      = w_wb_clr && (wb_rd == rs1);
  assign w_hit2      = w_wb_clr && (wb_rd == rs2);
  assign w_src1_busy = r_busy[rs1] && !w_hit1;
  assign w_src2_busy = r_busy[rs2] && !w_hit2;
  assign w_op1       = w_hit1 ? wb_data : read_data1;
  assign w_op2       = w_hit2 ? wb_data : read_data2;
`else
  logic w_unused_wb_data;
  assign w_unused_wb_data = ^wb_data;
  assign w_src1_busy      = r_busy[rs1];
  assign w_src2_busy      = r_busy[rs2];
  assign w_op1            = read_data1;
  assign w_op2            = read_data2;
`endif

  assign w_hazard = (w_use1 && w_src1_busy) || (w_use2 && w_src2_busy);
  assign w_issue  = r_id_valid && !w_hazard && (!ex_valid || ex_ready) && !flush;
  assign if_ready = (!r_id_valid || w_issue) && !flush;

  // Ordering gives issue-set priority over a same-cycle writeback clear.
  always_comb begin
    w_busy_nxt = r_busy;
    if (flush && ex_valid && ex_rd_wen) w_busy_nxt[ex_rd] = 1'b0;
    if (w_wb_clr)                       w_busy_nxt[wb_rd] = 1'b0;
    if (w_issue && w_rd_wen)            w_busy_nxt[w_rd]  = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_valid <= 1'b0;
      r_id_instr <= '0;
      r_id_pc    <= '0;
    end else if (flush) begin
      r_id_valid <= 1'b0;
    end else if (if_valid && if_ready) begin
      r_id_valid <= 1'b1;
      r_id_instr <= if_instr;
      r_id_pc    <= if_pc;
    end else if (w_issue) begin
      r_id_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= RESET_PC;
      ex_op1      <= '0;
      ex_op2      <= '0;
      ex_imm      <= '0;
      ex_rd       <= '0;
      ex_rd_wen   <= 1'b0;
      ex_opcode   <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      ex_illegal  <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (w_issue) begin
      ex_valid    <= 1'b1;
      ex_pc       <= r_id_pc;
      ex_op1      <= w_op1;
      ex_op2      <= w_op2;
      ex_imm      <= w_imm;
      ex_rd       <= w_rd;
      ex_rd_wen   <= w_rd_wen;
      ex_opcode   <= w_opcode;
      ex_funct3   <= r_id_instr[14:12];
      ex_funct7b5 <= r_id_instr[30];
      ex_illegal  <= w_illegal;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: decode vector table, hand-written hazard/
// backpressure/flush/reset sequences, and a random program against an in-order ISA model.
module tb_id_stage;
  localparam logic [31:0] RPC    = 32'h0000_1000;
  localparam int          NRAND  = 200;

  logic        clk, rst, if_valid, if_ready, wb_wEn, flush, ex_valid, ex_ready;
  logic [31:0] if_instr, if_pc, read_data1, read_data2, wb_data;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [4:0]  rs1, rs2, wb_rd, ex_rd;
  logic        ex_rd_wen, ex_funct7b5, ex_illegal;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;

  int errors = 0;
  int checks = 0;

  logic        tbl_mode = 1'b0;
  logic [31:0] regs [32];

  id_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .rs1(rs1), .rs2(rs2),
    .read_data1(read_data1), .read_data2(read_data2),
    .wb_wEn(wb_wEn), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_op1(ex_op1),
    .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: written at the clock edge, read combinationally.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_wEn && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end
  assign read_data1 = tbl_mode ? 32'h1111_1111 : regs[rs1];
  assign read_data2 = tbl_mode ? 32'h2222_2222 : regs[rs2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; ex_ready = 1'b0;
    wb_wEn = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [31:0] instr, pc, imm;
    logic [4:0]  rd, rs1, rs2;
    logic        wen, ill, chk_imm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
  } vec_t;
  vec_t vt [13];

  typedef struct {
    logic [31:0] pc, op1, op2, imm, res;
    logic        u1, u2, wen;
    logic [4:0]  rd;
  } exp_t;
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] v;
  } wb_t;
  exp_t        expq [$];
  wb_t         wbq  [$];
  logic [31:0] arch [32];
  logic [31:0] pc_ctr;
  int          gen_cnt;

  // Produce the next program instruction and its architecturally expected operands.
  task automatic gen_next();
    logic [31:0] pend;
    logic [4:0]  rdv, s1, s2;
    logic [11:0] i12;
    logic [19:0] u20;
    logic [12:0] b13;
    logic [31:0] ins;
    exp_t        e;
    pend = '0;
    foreach (expq[j]) if (expq[j].wen) pend[expq[j].rd] = 1'b1;
    foreach (wbq[j]) pend[wbq[j].rd] = 1'b1;
    rdv = 5'($urandom_range(1, 7));
    for (int t = 0; t < 8 && pend[rdv]; t++) rdv = 5'($urandom_range(0, 7));
    if (pend[rdv]) rdv = 5'd0;
    s1 = 5'($urandom_range(0, 7));
    s2 = 5'($urandom_range(0, 7));
    e.pc = pc_ctr; e.rd = rdv; e.u1 = 1'b0; e.u2 = 1'b0; e.wen = 1'b0;
    e.op1 = arch[s1]; e.op2 = arch[s2]; e.res = '0; e.imm = '0;
    case ($urandom_range(0, 3))
      0: begin
        i12 = 12'($urandom);
        ins = {i12, s1, 3'b000, rdv, 7'h13};
        e.u1 = 1'b1; e.imm = 32'($signed(i12)); e.res = arch[s1] + e.imm; e.wen = (rdv != 0);
      end
      1: begin
        ins = {7'h00, s2, s1, 3'b000, rdv, 7'h33};
        e.u1 = 1'b1; e.u2 = 1'b1; e.res = arch[s1] + arch[s2]; e.wen = (rdv != 0);
      end
      2: begin
        u20 = 20'($urandom);
        ins = {u20, rdv, 7'h37};
        e.imm = {u20, 12'h000}; e.res = e.imm; e.wen = (rdv != 0);
      end
      default: begin
        b13 = 13'($urandom) & 13'h1FFE;
        ins = {b13[12], b13[10:5], s2, s1, 3'b000, b13[4:1], b13[11], 7'h63};
        e.u1 = 1'b1; e.u2 = 1'b1; e.imm = 32'($signed(b13));
      end
    endcase
    if (e.wen) arch[rdv] = e.res;
    expq.push_back(e);
    if_instr = ins; if_pc = pc_ctr;
    pc_ctr += 32'd4;
    gen_cnt++;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0]  = '{32'h00500093, 32'h100, 32'h00000005, 5'd1,  5'd0,  5'd5,  1, 0, 1, 7'h13, 3'd0, 0};
    vt[1]  = '{32'hFE000EE3, 32'h200, 32'hFFFFFFFC, 5'd0,  5'd0,  5'd0,  0, 0, 1, 7'h63, 3'd0, 1};
    vt[2]  = '{32'h123452B7, 32'h204, 32'h12345000, 5'd5,  5'd8,  5'd3,  1, 0, 1, 7'h37, 3'd5, 0};
    vt[3]  = '{32'hFE20AC23, 32'h208, 32'hFFFFFFF8, 5'd0,  5'd1,  5'd2,  0, 0, 1, 7'h23, 3'd2, 1};
    vt[4]  = '{32'h001000EF, 32'h20C, 32'h00000800, 5'd1,  5'd0,  5'd1,  1, 0, 1, 7'h6F, 3'd0, 0};
    vt[5]  = '{32'hFFFFF397, 32'h210, 32'hFFFFF000, 5'd7,  5'd31, 5'd31, 1, 0, 1, 7'h17, 3'd7, 1};
    vt[6]  = '{32'hFFFFFFFF, 32'h214, 32'h00000000, 5'd0,  5'd31, 5'd31, 0, 1, 0, 7'h7F, 3'd7, 1};
    vt[7]  = '{32'h002081B3, 32'h218, 32'h00000000, 5'd3,  5'd1,  5'd2,  1, 0, 1, 7'h33, 3'd0, 0};
    vt[8]  = '{32'h402081B3, 32'h21C, 32'h00000000, 5'd3,  5'd1,  5'd2,  1, 0, 1, 7'h33, 3'd0, 1};
    vt[9]  = '{32'h00000013, 32'h220, 32'h00000000, 5'd0,  5'd0,  5'd0,  0, 0, 1, 7'h13, 3'd0, 0};
    vt[10] = '{32'hFFF100E7, 32'h224, 32'hFFFFFFFF, 5'd1,  5'd2,  5'd31, 1, 0, 1, 7'h67, 3'd0, 1};
    vt[11] = '{32'h0101A203, 32'h228, 32'h00000010, 5'd4,  5'd3,  5'd16, 1, 0, 1, 7'h03, 3'd2, 0};
    vt[12] = '{32'h00209463, 32'h22C, 32'h00000008, 5'd0,  5'd1,  5'd2,  0, 0, 1, 7'h63, 3'd1, 0};

    // Reset state.
    do_reset();
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_id_valid", 32'(dut.r_id_valid), 32'd0);
    check("rst_ex_pc", ex_pc, RPC);
    check("rst_ex_op1", ex_op1, 32'd0);
    check("rst_ex_imm", ex_imm, 32'd0);
    check("rst_ex_rd", 32'(ex_rd), 32'd0);
    check("rst_busy", dut.r_busy, 32'd0);
    check("rst_if_ready", 32'(if_ready), 32'd1);

    // Single-instruction decode vectors, each from a clean reset.
    foreach (vt[k]) begin
      do_reset();
      tbl_mode = 1'b1;
      ex_ready = 1'b1; if_valid = 1'b1; if_instr = vt[k].instr; if_pc = vt[k].pc;
      #1 check($sformatf("v%0d_if_ready", k), 32'(if_ready), 32'd1);
      @(posedge clk); @(negedge clk);
      if_valid = 1'b0;
      #1;
      check($sformatf("v%0d_rs1", k), 32'(rs1), 32'(vt[k].rs1));
      check($sformatf("v%0d_rs2", k), 32'(rs2), 32'(vt[k].rs2));
      check($sformatf("v%0d_ex_valid_early", k), 32'(ex_valid), 32'd0);
      @(posedge clk); #1;
      check($sformatf("v%0d_ex_valid", k), 32'(ex_valid), 32'd1);
      check($sformatf("v%0d_pc", k), ex_pc, vt[k].pc);
      check($sformatf("v%0d_op1", k), ex_op1, 32'h1111_1111);
      check($sformatf("v%0d_op2", k), ex_op2, 32'h2222_2222);
      if (vt[k].chk_imm) check($sformatf("v%0d_imm", k), ex_imm, vt[k].imm);
      if (vt[k].wen) check($sformatf("v%0d_rd", k), 32'(ex_rd), 32'(vt[k].rd));
      check($sformatf("v%0d_rd_wen", k), 32'(ex_rd_wen), 32'(vt[k].wen));
      check($sformatf("v%0d_illegal", k), 32'(ex_illegal), 32'(vt[k].ill));
      check($sformatf("v%0d_opcode", k), 32'(ex_opcode), 32'(vt[k].op));
      check($sformatf("v%0d_funct3", k), 32'(ex_funct3), 32'(vt[k].f3));
      check($sformatf("v%0d_f7b5", k), 32'(ex_funct7b5), 32'(vt[k].f7));
      check($sformatf("v%0d_busy", k), dut.r_busy, vt[k].wen ? (32'd1 << vt[k].rd) : 32'd0);
      tbl_mode = 1'b0;
    end

    // RAW hazard: ADDI x1 then ADD x2,x1,x1 held until writeback of x1.
    do_reset();
    ex_ready = 1'b1; if_valid = 1'b1; if_instr = 32'h00500093; if_pc = 32'h0;
    @(posedge clk); @(negedge clk);
    if_instr = 32'h00108133; if_pc = 32'h4;
    #1 check("haz_accept_add", 32'(if_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    if_instr = 32'h00000013; if_pc = 32'h8;
    #1;
    check("haz_addi_valid", 32'(ex_valid), 32'd1);
    check("haz_addi_rd", 32'(ex_rd), 32'd1);
    check("haz_stall_ready", 32'(if_ready), 32'd0);
    @(posedge clk); @(negedge clk); #1;
    check("haz_bubble", 32'(ex_valid), 32'd0);
    check("haz_stall_ready2", 32'(if_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    wb_wEn = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
    #1;
`ifdef WB_BYPASS_EN
    check("haz_wb_cycle_ready", 32'(if_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    wb_wEn = 1'b0; if_valid = 1'b0;
    #1;
`else
    check("haz_wb_cycle_ready", 32'(if_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    wb_wEn = 1'b0;
    #1;
    check("haz_wb_cycle_exv", 32'(ex_valid), 32'd0);
    check("haz_post_wb_ready", 32'(if_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    if_valid = 1'b0;
    #1;
`endif
    check("haz_add_valid", 32'(ex_valid), 32'd1);
    check("haz_add_rd", 32'(ex_rd), 32'd2);
    check("haz_add_op1", ex_op1, 32'd5);
    check("haz_add_op2", ex_op2, 32'd5);

    // Asynchronous reset during a stall.
    do_reset();
    ex_ready = 1'b1; if_valid = 1'b1; if_instr = 32'h00500093; if_pc = 32'h40;
    @(posedge clk); @(negedge clk);
    if_instr = 32'h00108133; if_pc = 32'h44;
    @(posedge clk); @(negedge clk);
    if_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_ex_valid", 32'(ex_valid), 32'd0);
    check("arst_id_valid", 32'(dut.r_id_valid), 32'd0);
    check("arst_busy", dut.r_busy, 32'd0);
    check("arst_ex_pc", ex_pc, RPC);
    @(negedge clk); rst = 1'b0;

    // Backpressure: ex_ready low holds ID/EX and ID, blocks the third fetch.
    do_reset();
    ex_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h00700293; if_pc = 32'h10;
    @(posedge clk); @(negedge clk);
    if_instr = 32'h00900313; if_pc = 32'h14;
    #1 check("bp_accept_i2", 32'(if_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    if_instr = 32'h00000013; if_pc = 32'h18;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp_hold%0d_valid", c), 32'(ex_valid), 32'd1);
      check($sformatf("bp_hold%0d_pc", c), ex_pc, 32'h10);
      check($sformatf("bp_hold%0d_imm", c), ex_imm, 32'd7);
      check($sformatf("bp_hold%0d_rd", c), 32'(ex_rd), 32'd5);
      check($sformatf("bp_hold%0d_if_ready", c), 32'(if_ready), 32'd0);
      @(posedge clk); @(negedge clk);
    end
    ex_ready = 1'b1;
    #1 check("bp_release_ready", 32'(if_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    if_valid = 1'b0;
    #1;
    check("bp_i2_pc", ex_pc, 32'h14);
    check("bp_i2_imm", ex_imm, 32'd9);
    check("bp_i2_rd", 32'(ex_rd), 32'd6);

    // Flush with a valid ID/EX entry writing x3.
    do_reset();
    ex_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h00100193; if_pc = 32'h20;
    @(posedge clk); @(negedge clk);
    if_instr = 32'h00000013; if_pc = 32'h24;
    @(posedge clk); @(negedge clk);
    #1;
    check("fl_pre_valid", 32'(ex_valid), 32'd1);
    check("fl_pre_busy3", 32'(dut.r_busy[3]), 32'd1);
    flush = 1'b1; if_instr = 32'h00000013; if_pc = 32'h28;
    #1 check("fl_if_ready", 32'(if_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    flush = 1'b0; if_valid = 1'b0;
    #1;
    check("fl_ex_valid", 32'(ex_valid), 32'd0);
    check("fl_id_valid", 32'(dut.r_id_valid), 32'd0);
    check("fl_busy3", 32'(dut.r_busy[3]), 32'd0);

    // Random program against the in-order architectural model.
    do_reset();
    for (int i = 0; i < 32; i++) arch[i] = '0;
    expq.delete(); wbq.delete();
    pc_ctr = 32'h4000; gen_cnt = 0;
    begin
      int  consumed;
      int  cyc;
      bit  have_pres;
      exp_t e;
      consumed = 0; cyc = 0; have_pres = 1'b0;
      while (consumed < NRAND && cyc < 8000) begin
        @(negedge clk);
        cyc++;
        ex_ready = ($urandom_range(0, 3) != 0);
        if (wbq.size() > 0 && $urandom_range(0, 1) == 1) begin
          wb_wEn = 1'b1; wb_rd = wbq[0].rd; wb_data = wbq[0].v;
          void'(wbq.pop_front());
        end else begin
          wb_wEn = 1'b0;
        end
        if (!have_pres && gen_cnt < NRAND && $urandom_range(0, 3) != 0) begin
          gen_next();
          have_pres = 1'b1;
        end
        if_valid = have_pres;
        #1;
        if (ex_valid && ex_ready) begin
          if (expq.size() == 0) begin
            check("rnd_spurious_issue", 32'(ex_valid), 32'd0);
          end else begin
            e = expq.pop_front();
            check("rnd_pc", ex_pc, e.pc);
            check("rnd_imm", ex_imm, e.imm);
            check("rnd_rd_wen", 32'(ex_rd_wen), 32'(e.wen));
            if (e.u1) check("rnd_op1", ex_op1, e.op1);
            if (e.u2) check("rnd_op2", ex_op2, e.op2);
            if (e.wen) begin
              check("rnd_rd", 32'(ex_rd), 32'(e.rd));
              wbq.push_back('{e.rd, e.res});
            end
            consumed++;
          end
        end
        if (if_valid && if_ready) have_pres = 1'b0;
      end
      wb_wEn = 1'b0; if_valid = 1'b0;
      check("rnd_completed", 32'(consumed), 32'(NRAND));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the RV32I pipeline, sitting directly upstream of `regfile`. It accepts fetched instructions over a valid/ready handshake and drives `rs1`/`rs2` into the register file. It holds RAW-hazard instructions using a busy-bit scoreboard cleared by writeback, and registers decoded operands into the ID/EX pipeline register for the execute stage.

## Interface

- `XLEN`, 32: datapath width.
- `RESET_PC`, 32'h0000_0000: reset value of `ex_pc`.

- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `if_valid`  in  1: fetch presents an instruction.
- `if_ready`  out  1: stage accepts the instruction this cycle.
- `if_instr`  in  32: instruction word.
- `if_pc`  in  XLEN: instruction address.
- `rs1`, `rs2`  out  5: register-file read addresses.
- `read_data1`, `read_data2`  in  XLEN: register-file read data, combinational.
- `wb_wEn`  in  1: writeback writes the register file this cycle.
- `wb_rd`  in  5: writeback destination.
- `wb_data`  in  XLEN: writeback data.
- `flush`  in  1: kill all instructions held in ID and ID/EX.
- `ex_valid`  out  1: ID/EX register holds an instruction.
- `ex_ready`  in  1: execute accepts the instruction.
- `ex_pc`, `ex_op1`, `ex_op2`, `ex_imm`  out  XLEN: PC, rs1 value, rs2 value, sign-extended immediate.
- `ex_rd`  out  5: destination register; `ex_rd_wen`  out  1: instruction writes `rd`.
- `ex_opcode`  out  7; `ex_funct3`  out  3; `ex_funct7b5`  out  1: decode fields for the ALU.
- `ex_illegal`  out  1: opcode is not RV32I.

## Operation

- ID register (`id_valid`, `id_instr`, `id_pc`) loads on `if_valid && if_ready`.
- `if_ready = !id_valid || issue`.
- `rs1`/`rs2` are driven combinationally from instruction bits [19:15]/[24:20].
- Use flags come from the opcode:
  - `use_rs1`: R, I, S, B, JALR.
  - `use_rs2`: R, S, B.
  - `rd_wen`: R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC, and only when rd≠0.
- Scoreboard: 32 busy bits; bit 0 is hardwired to 0.
- `hazard = (use_rs1 && busy[rs1]) || (use_rs2 && busy[rs2])`.
- `issue = id_valid && !hazard && (!ex_valid || ex_ready) && !flush`.
- On `issue`:
  - load ID/EX with `read_data1`, `read_data2`, the immediate, and the fields above;
  - set `busy[rd]` when `rd_wen`.
- `wb_wEn` with `wb_rd≠0` clears `busy[wb_rd]`.
  - If an issue sets the same bit in the same cycle, the set wins.
- `ex_valid` clears on `ex_ready && !issue`.
- Illegal opcodes still issue with `ex_illegal=1`, `rd_wen=0`, and operands taken as read.
- `flush`:
  - clears `id_valid` and `ex_valid`;
  - clears `busy[ex_rd]` if `ex_valid && ex_rd_wen`;
  - blocks that cycle's fetch accept (`if_ready=0`).
- Immediates:
  - I/S/B/U/J are formed per RV32I and sign-extended to XLEN.
  - B and J bit 0 is 0.
  - R-type immediate is 0.

## Timing

- Reset: `ex_valid=0`, `id_valid=0`, all `ex_*` data outputs 0, `ex_pc=RESET_PC`, busy vector 0.
- `if_ready=1` the first cycle after reset releases.
- Latency: fetch accept at edge N gives `ex_valid=1` after edge N+1 when there is no hazard or backpressure.
- Throughput: one instruction per cycle.
- The regfile write and the busy clear happen on the same edge.
- A stalled instruction issues one cycle after the writeback cycle and reads the new value.
- Back-to-back dependent instructions therefore stall until the producer's writeback.
- Reset asserted mid-stall discards all state immediately (asynchronous).

## Configuration

- `WB_BYPASS_EN` defined:
  - a source whose busy bit is being cleared this cycle by `wb_wEn/wb_rd` is not a hazard;
  - `ex_op1`/`ex_op2` capture `wb_data` instead of `read_data*` for that source;
  - the instruction issues in the writeback cycle, saving one stall cycle.
- Undefined: no bypass; the instruction stalls until the cycle after writeback, as in Timing.

## Structure

- Shared package `riscv_pkg` holds:
  - opcode constants (`OP_R`, `OP_IMM`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`, `OP_JAL`, `OP_JALR`, `OP_LUI`, `OP_AUIPC`);
  - the immediate-format enum `imm_fmt_t`;
  - `XLEN` and `REG_ADDR_W=5`.
- One sub-module, `imm_gen`, is combinational: it maps instruction + `imm_fmt_t` to an XLEN immediate.
- Scoreboard, handshake, and pipeline registers stay in `id_stage`.

## Test plan

- ADDI x1,x0,5 (0x00500093) at pc 0x0, ex_ready=1 -> next cycle ex_valid=1, ex_rd=1, ex_imm=5, ex_rd_wen=1, ex_pc=0; busy[1]=1.
- ADDI x1 then ADD x2,x1,x1; pulse wb_wEn/wb_rd=1/wb_data=5 after 3 cycles -> ADD holds, if_ready=0 until busy[1] clears. Then:
  - without `WB_BYPASS_EN`: ADD issues the next cycle with ex_op1=ex_op2=5;
  - with `WB_BYPASS_EN`: ADD issues in the writeback cycle with ex_op1=ex_op2=5.
- ex_ready=0 with a valid ID/EX entry -> ex_* outputs stable, second instruction waits in ID, third fetch sees if_ready=0.
- BEQ x0,x0,-4 (0xFE000EE3) -> ex_imm=0xFFFFFFFC, ex_rd_wen=0, no busy bit set.
- ADDI x3 issued, then flush with ex_valid=1 -> ex_valid=0, id_valid=0, busy[3]=0 next cycle.
- Instruction 0xFFFFFFFF -> issues with ex_illegal=1, ex_rd_wen=0; writes to x0 never set busy[0].
